// File: rtl/core_pipe_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
// Shared definitions for the core pipeline stage buffers.
//   cnt_w(depth)   : width of an occupancy counter able to hold 0..depth
//   ptr_w(depth)   : width of a circular-buffer pointer (at least 1 bit)
//   *_t structs    : packed stage payloads; wrappers pack them into the
//                    WIDTH-bit s_data/m_data of core_stage_buf.
// ---------------------------------------------------------------------------
package core_pipe_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;

    // Occupancy counter width for a buffer of 'depth' entries (0..depth).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry buffer still gets a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_SYS    = 3'd5
    } op_class_e;

    // Decode -> execute payload.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        op_class_e         op;
        logic              rd_we;
    } dec_ex_t;

    // Execute -> memory payload.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   store_val;
        logic [REG_AW-1:0] rd;
        op_class_e         op;
        logic              rd_we;
    } ex_mem_t;

    // Memory -> writeback payload.
    typedef struct packed {
        logic [XLEN-1:0]   wb_val;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
    } mem_wb_t;

endpackage

// File: rtl/core_stage_buf.sv
// ---------------------------------------------------------------------------
// core_stage_buf
// Elastic pipeline register between two core stages. Holds up to DEPTH
// beats in a circular buffer under a valid/ready handshake. s_ready is a
// function of registered state (plus flush/rst), so no combinational ready
// chain runs through this block. Optional empty-buffer bypass (BYPASS=1).
//
// Parameters
//   WIDTH  payload width (>=1)
//   DEPTH  number of entries (>=1); DEPTH>=2 sustains one beat per cycle
//   BYPASS 1: an empty buffer forwards s_data to m_data combinationally
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   flush    synchronous kill of held beats and the incoming beat
//   s_valid  upstream beat valid          s_ready  buffer can accept
//   s_data   upstream payload
//   m_valid  downstream beat valid        m_ready  downstream accepts
//   m_data   downstream payload (meaningful only with m_valid=1)
//   count    number of held entries
// ---------------------------------------------------------------------------
module core_stage_buf
    import core_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Reject meaningless geometries at elaboration.
    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
        $fatal(1, "core_stage_buf: DEPTH (%0d) and WIDTH (%0d) must both be >= 1",
               DEPTH, WIDTH);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic bypass_taken;
    logic push;
    logic pop;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Only registered occupancy, flush and rst feed s_ready; m_ready never
    // does, so a full buffer stays not-ready for the cycle in which it pops.
    assign s_ready = !rst && !flush && !full;

    always_comb begin
        m_valid = 1'b0;
        m_data  = mem_q[rd_ptr_q];
        if (rst || flush) begin
            m_valid = 1'b0;
        end else if (!empty) begin
            m_valid = 1'b1;
        end else if (BYPASS) begin
            m_valid = s_valid;
            m_data  = s_data;
        end
    end

    // A bypassed beat goes straight through and is never written to memory.
    assign bypass_taken = BYPASS && empty && s_valid && m_ready && !flush && !rst;
    assign push         = s_valid && s_ready && !bypass_taken;
    assign pop          = m_valid && m_ready && !empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage: one write-enabled register per entry, never reset. push is
    // already suppressed by flush/rst through s_ready.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= s_data;
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_core_stage_buf.sv
module tb_core_stage_buf;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    // Instance A: DEPTH=2, BYPASS=0
    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [31:0] a_s_data, a_m_data;
    logic [1:0]  a_count;
    // Instance B: DEPTH=3, BYPASS=0
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_m_data;
    logic [1:0]  b_count;
    // Instance C: DEPTH=1, BYPASS=1
    logic        c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [31:0] c_s_data, c_m_data;
    logic [0:0]  c_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    core_stage_buf #(.WIDTH(32), .DEPTH(2), .BYPASS(1'b0)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count)
    );

    core_stage_buf #(.WIDTH(32), .DEPTH(3), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count)
    );

    core_stage_buf #(.WIDTH(32), .DEPTH(1), .BYPASS(1'b1)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
        .count(c_count)
    );

    task automatic test_reset();
        @(negedge clk);
        #1;
        vec_cnt++;
        if (a_s_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_sready_in_rst: got %b expected 0", a_s_ready); end
        vec_cnt++;
        if (a_m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_mvalid: got %b expected 0", a_m_valid); end
        vec_cnt++;
        if (a_count !== 2'd0) begin err_cnt++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        rst = 1'b0;
        #1;
        vec_cnt++;
        if ({a_s_ready, b_s_ready, c_s_ready} !== 3'b111) begin
            err_cnt++; $display("FAIL reset_sready_release: got %b expected 111", {a_s_ready, b_s_ready, c_s_ready});
        end
        vec_cnt++;
        if ({b_count, c_count} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_count_bc: got %b expected 000", {b_count, c_count});
        end
        $display("reset: released");
    endtask

    task automatic test_stream();
        logic [31:0] din [3];
        logic        exp_mv;
        din = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_s_valid = (i < 3);
            a_s_data  = (i < 3) ? din[i] : 32'h0;
            a_m_ready = 1'b1;
            #1;
            exp_mv = (i >= 1 && i <= 3);
            vec_cnt++;
            if (a_m_valid !== exp_mv) begin err_cnt++; $display("FAIL stream_mvalid[%0d]: got %b expected %b", i, a_m_valid, exp_mv); end
            vec_cnt++;
            if (a_count !== {1'b0, exp_mv}) begin err_cnt++; $display("FAIL stream_count[%0d]: got %0d expected %0d", i, a_count, exp_mv); end
            vec_cnt++;
            if (a_s_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_sready[%0d]: got %b expected 1", i, a_s_ready); end
            if (exp_mv) begin
                vec_cnt++;
                if (a_m_data !== din[i-1]) begin err_cnt++; $display("FAIL stream_data[%0d]: got %h expected %h", i, a_m_data, din[i-1]); end
                $display("stream: beat out %h", a_m_data);
            end
        end
        a_s_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] sd [7];
        logic [31:0] md [7];
        logic [6:0]  sv, mr, es, ev;
        logic [1:0]  ec [7];
        sd = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'h0, 32'h0};
        md = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'h0};
        ec = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        // bit i = cycle i
        sv = 7'b0011111;
        mr = 7'b1111000;
        es = 7'b1110011;
        ev = 7'b0111110;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_s_valid = sv[i];
            a_s_data  = sd[i];
            a_m_ready = mr[i];
            #1;
            vec_cnt++;
            if (a_s_ready !== es[i]) begin err_cnt++; $display("FAIL bp_sready[%0d]: got %b expected %b", i, a_s_ready, es[i]); end
            vec_cnt++;
            if (a_count !== ec[i]) begin err_cnt++; $display("FAIL bp_count[%0d]: got %0d expected %0d", i, a_count, ec[i]); end
            vec_cnt++;
            if (a_m_valid !== ev[i]) begin err_cnt++; $display("FAIL bp_mvalid[%0d]: got %b expected %b", i, a_m_valid, ev[i]); end
            if (ev[i]) begin
                vec_cnt++;
                if (a_m_data !== md[i]) begin err_cnt++; $display("FAIL bp_data[%0d]: got %h expected %h", i, a_m_data, md[i]); end
            end
            if (ev[i] && mr[i]) $display("backpressure: beat out %h", a_m_data);
        end
        a_s_valid = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_s_valid = 1'b1;
            a_s_data  = (i == 0) ? 32'hB0 : 32'hB1;
            a_m_ready = 1'b0;
        end
        @(negedge clk);
        flush     = 1'b1;
        a_s_valid = 1'b1;
        a_s_data  = 32'hB2;
        a_m_ready = 1'b1;
        #1;
        vec_cnt++;
        if (a_count !== 2'd2) begin err_cnt++; $display("FAIL flush_prefill_count: got %0d expected 2", a_count); end
        vec_cnt++;
        if (a_m_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_mvalid: got %b expected 0", a_m_valid); end
        vec_cnt++;
        if (a_s_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_sready: got %b expected 0", a_s_ready); end
        $display("flush: asserted with count=%0d", a_count);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush     = 1'b0;
            a_s_valid = 1'b0;
            a_m_ready = 1'b1;
            #1;
            vec_cnt++;
            if (a_count !== 2'd0) begin err_cnt++; $display("FAIL flush_count[%0d]: got %0d expected 0", i, a_count); end
            vec_cnt++;
            if (a_m_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_leak[%0d]: got m_valid=%b data=%h expected 0", i, a_m_valid, a_m_data); end
        end
    endtask

    task automatic test_wrap();
        int nin  = 0;
        int nout = 0;
        int cyc  = 0;
        int mcnt;
        while (nout < 10 && cyc < 80) begin
            @(negedge clk);
            b_s_valid = (nin < 10);
            b_s_data  = 32'(nin);
            b_m_ready = (cyc % 2 == 0);
            #1;
            mcnt = nin - nout;
            vec_cnt++;
            if (b_count !== 2'(mcnt) || mcnt > 3) begin err_cnt++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", cyc, b_count, mcnt); end
            vec_cnt++;
            if (b_s_ready !== (mcnt < 3)) begin err_cnt++; $display("FAIL wrap_sready[%0d]: got %b expected %b", cyc, b_s_ready, (mcnt < 3)); end
            vec_cnt++;
            if (b_m_valid !== (mcnt > 0)) begin err_cnt++; $display("FAIL wrap_mvalid[%0d]: got %b expected %b", cyc, b_m_valid, (mcnt > 0)); end
            if (b_m_valid && b_m_ready) begin
                vec_cnt++;
                if (b_m_data !== 32'(nout)) begin err_cnt++; $display("FAIL wrap_data[%0d]: got %h expected %h", cyc, b_m_data, 32'(nout)); end
                $display("wrap: beat out %0d", b_m_data);
                nout++;
            end
            if (b_s_valid && b_s_ready) nin++;
            cyc++;
        end
        vec_cnt++;
        if (nout != 10) begin err_cnt++; $display("FAIL wrap_timeout: got %0d beats expected 10", nout); end
        b_s_valid = 1'b0;
    endtask

    task automatic test_bypass();
        logic [5:0] sv, mr, ev, es;
        logic [0:0] ec [6];
        sv = 6'b000101;
        mr = 6'b110001;
        ev = 6'b011101;
        es = 6'b100111;
        ec = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_s_valid = sv[i];
            c_s_data  = sv[i] ? 32'hC5 : 32'h0;
            c_m_ready = mr[i];
            #1;
            vec_cnt++;
            if (c_m_valid !== ev[i]) begin err_cnt++; $display("FAIL byp_mvalid[%0d]: got %b expected %b", i, c_m_valid, ev[i]); end
            vec_cnt++;
            if (c_count !== ec[i]) begin err_cnt++; $display("FAIL byp_count[%0d]: got %0d expected %0d", i, c_count, ec[i]); end
            vec_cnt++;
            if (c_s_ready !== es[i]) begin err_cnt++; $display("FAIL byp_sready[%0d]: got %b expected %b", i, c_s_ready, es[i]); end
            if (ev[i]) begin
                vec_cnt++;
                if (c_m_data !== 32'hC5) begin err_cnt++; $display("FAIL byp_data[%0d]: got %h expected c5", i, c_m_data); end
            end
            if (ev[i] && mr[i]) $display("bypass: beat out %h", c_m_data);
        end
        c_s_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_s_valid = 1'b1;
            a_s_data  = (i == 0) ? 32'hD0 : 32'hD1;
            a_m_ready = 1'b0;
        end
        @(negedge clk);
        a_s_valid = 1'b0;
        #1;
        vec_cnt++;
        if (a_count !== 2'd2) begin err_cnt++; $display("FAIL arst_prefill: got %0d expected 2", a_count); end
        #1 rst = 1'b1;
        #1;
        vec_cnt++;
        if (a_count !== 2'd0) begin err_cnt++; $display("FAIL arst_count: got %0d expected 0", a_count); end
        vec_cnt++;
        if (a_m_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_mvalid: got %b expected 0", a_m_valid); end
        vec_cnt++;
        if (a_s_ready !== 1'b0) begin err_cnt++; $display("FAIL arst_sready: got %b expected 0", a_s_ready); end
        #1 rst = 1'b0;
        $display("async reset: pulsed mid-stream");
        @(negedge clk);
        a_s_valid = 1'b1;
        a_s_data  = 32'hE0;
        a_m_ready = 1'b1;
        #1;
        vec_cnt++;
        if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
            err_cnt++; $display("FAIL arst_after: got mv=%b sr=%b expected mv=0 sr=1", a_m_valid, a_s_ready);
        end
        @(negedge clk);
        a_s_valid = 1'b0;
        #1;
        vec_cnt++;
        if (a_m_valid !== 1'b1 || a_m_data !== 32'hE0) begin
            err_cnt++; $display("FAIL arst_latency: got mv=%b data=%h expected mv=1 data=e0", a_m_valid, a_m_data);
        end
        $display("async reset: beat out %h", a_m_data);
        @(negedge clk);
        #1;
        vec_cnt++;
        if (a_count !== 2'd0 || a_m_valid !== 1'b0) begin
            err_cnt++; $display("FAIL arst_drain: got count=%0d mv=%b expected 0/0", a_count, a_m_valid);
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
        c_s_valid = 1'b0; c_s_data = '0; c_m_ready = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_bypass();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
